// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one adder, an iteration counter and a
// three-state FSM behind a start/done handshake. product = a * b after WIDTH steps.
module seq_shift_add_multiplier #(
   parameter int WIDTH = 10,
   parameter int CNT_W = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t                 state_r;
   state_t                 state_s;
   logic [WIDTH-1:0]       mcand_r;
   logic [2*WIDTH:0]       p_r;
   logic [CNT_W-1:0]       cnt_r;
   logic [2*WIDTH-1:0]     product_r;
   logic                   ready_r;
   logic                   busy_r;
   logic                   done_r;

   logic                   load_s;
   logic                   step_s;
   logic                   last_s;
   logic [WIDTH:0]         upper_s;
   logic [2*WIDTH:0]       p_step_s;

   // One shift-add step: the accumulator keeps its carry, so the shift never loses a bit.
   always_comb begin
      upper_s  = p_r[2*WIDTH:WIDTH];
      p_step_s = p_r;
      if (p_r[0]) begin
         upper_s = p_r[2*WIDTH:WIDTH] + {1'b0, mcand_r};
      end else begin
         upper_s = p_r[2*WIDTH:WIDTH];
      end
      p_step_s = {1'b0, upper_s, p_r[WIDTH-1:1]};
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_s = state_r;
      load_s  = 1'b0;
      step_s  = 1'b0;
      last_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_s = S_CALC;
               load_s  = 1'b1;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_CALC: begin
            step_s = 1'b1;
            if (cnt_r == LAST_CNT) begin
               state_s = S_DONE;
               last_s  = 1'b1;
            end else begin
               state_s = S_CALC;
            end
         end
         S_DONE: begin
            state_s = S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // State register with handshake outputs registered from the next state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= S_IDLE;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         ready_r <= (state_s == S_IDLE);
         busy_r  <= (state_s == S_CALC) || (state_s == S_DONE);
         done_r  <= (state_s == S_DONE);
      end
   end

   // Operand capture, iteration and result register.
   always_ff @(posedge clock) begin
      if (reset) begin
         mcand_r   <= '0;
         p_r       <= '0;
         cnt_r     <= '0;
         product_r <= '0;
      end else if (load_s) begin
         mcand_r   <= a;
         p_r       <= {{(WIDTH+1){1'b0}}, b};
         cnt_r     <= '0;
         product_r <= '0;
      end else if (step_s) begin
         p_r   <= p_step_s;
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         if (last_s) begin
            product_r <= p_step_s[2*WIDTH-1:0];
         end else begin
            product_r <= product_r;
         end
      end else begin
         mcand_r   <= mcand_r;
         p_r       <= p_r;
         cnt_r     <= cnt_r;
         product_r <= product_r;
      end
   end

   assign ready   = ready_r;
   assign busy    = busy_r;
   assign done    = done_r;
   assign product = product_r;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier: expected products are queued at issue
// and compared when done pulses.
module tb_seq_shift_add_multiplier;
   localparam int WIDTH = 10;
   localparam int CNT_W = 4;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic                 start = 1'b0;
   logic [WIDTH-1:0]     a = '0;
   logic [WIDTH-1:0]     b = '0;
   logic                 ready;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   int                   errors = 0;
   int                   checks = 0;
   int                   done_cnt = 0;
   int                   cyc = 0;
   int                   last_done_cyc = 0;
   logic                 prev_done = 1'b0;
   logic [2*WIDTH-1:0]   exp_q[$];

   seq_shift_add_multiplier #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Scoreboard: every done pulse must be one cycle wide and match the oldest pending result.
   always @(negedge clock) begin
      if (done) begin
         done_cnt <= done_cnt + 1;
         last_done_cyc <= cyc;
         check("done_width", {31'd0, prev_done}, 32'd0);
         check("sb_pending", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) check("product", {12'd0, product}, {12'd0, exp_q.pop_front()});
      end
      prev_done <= done;
   end

   task automatic issue(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi, output int waited);
      logic [2*WIDTH-1:0] e;
      waited = 0;
      while (!ready && waited < 50) begin
         @(posedge clock); #1;
         waited++;
      end
      check("ready_wait", {31'd0, ready}, 32'd1);
      e = {{WIDTH{1'b0}}, ai} * {{WIDTH{1'b0}}, bi};
      a = ai; b = bi; start = 1'b1;
      exp_q.push_back(e);
      @(posedge clock); #1;
      start = 1'b0;
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      check("busy_after_start", {31'd0, busy}, 32'd1);
      check("product_cleared", {12'd0, product}, 32'd0);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clock); #1;
         lat++;
      end while (!done && lat < 40);
   endtask

   initial begin
      int lat;
      int w;
      int base;
      int d1;
      logic [WIDTH-1:0] ops_a [4] = '{10'd1023, 10'd0, 10'd777, 10'd0};
      logic [WIDTH-1:0] ops_b [4] = '{10'd1023, 10'd777, 10'd0, 10'd0};

      // 1. reset
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_product", {12'd0, product}, 32'd0);

      // 2. 5*3, latency counted in edges after the accepting edge
      issue(10'd5, 10'd3, w);
      wait_done(lat);
      check("latency", lat, WIDTH);
      @(posedge clock); #1;
      check("done_drop", {31'd0, done}, 32'd0);
      check("ready_after_done", {31'd0, ready}, 32'd1);
      check("product_hold", {12'd0, product}, 32'd15);

      // 3. corner operands
      for (int i = 0; i < 4; i++) begin
         issue(ops_a[i], ops_b[i], w);
         wait_done(lat);
         check("latency_corner", lat, WIDTH);
      end
      repeat (3) @(posedge clock);
      #1 check("product_hold_zero", {12'd0, product}, 32'd0);

      // 4. start during CALC and DONE is ignored
      base = done_cnt;
      issue(10'd12, 10'd10, w);
      repeat (3) @(posedge clock);
      #1 a = 10'd3; b = 10'd3; start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      wait_done(lat);
      check("latency_ignored_start", lat, WIDTH - 4);
      start = 1'b1; a = 10'd3; b = 10'd3;
      @(posedge clock); #1 start = 1'b0;
      check("idle_after_done", {31'd0, ready}, 32'd1);
      repeat (20) @(posedge clock);
      #1 check("single_done", done_cnt - base, 1);
      check("product_120", {12'd0, product}, 32'd120);

      // 5. reset mid-calculation
      issue(10'd100, 10'd200, w);
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      check("abort_ready", {31'd0, ready}, 32'd1);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_product", {12'd0, product}, 32'd0);
      reset = 1'b0;
      exp_q.delete();
      base = done_cnt;
      repeat (15) @(posedge clock);
      #1 check("abort_no_done", done_cnt - base, 0);
      issue(10'd7, 10'd9, w);
      wait_done(lat);
      check("latency_after_abort", lat, WIDTH);

      // 6. back-to-back issue on the first ready cycle
      issue(10'd2, 10'd3, w);
      wait_done(lat);
      d1 = cyc;
      issue(10'd1000, 10'd2, w);
      check("first_ready_cycle", w, 1);
      wait_done(lat);
      check("done_spacing", cyc - d1, WIDTH + 2);
      repeat (3) @(posedge clock);
      #1 check("product_2000", {12'd0, product}, 32'd2000);

      check("sb_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
